// File: rtl/mmio_input_ctrl.sv
// Memory-mapped input peripheral: synchronises, debounces and edge-detects IR and switch inputs,
// latches rising edges as sticky W1C events, raises a maskable irq and overlays the read path.
module mmio_input_ctrl #(
  parameter int SW_W      = 5,
  parameter int DEB_CYC   = 16,
  parameter int ADDR_W    = 5,
  parameter int ADDR_MASK = 28,
  parameter int ADDR_IR   = 29,
  parameter int ADDR_SW   = 30,
  parameter int ADDR_EVT  = 31
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       ReadData,
  input  logic [SW_W-1:0]   sw,
  input  logic              IR,
  input  logic [ADDR_W-1:0] dir,
  input  logic              MemWrite,
  input  logic [31:0]       WriteData,
  output logic [31:0]       ReadDataOut,
  output logic              irq
);

  localparam int NCH = SW_W + 1;
  localparam int CW  = $clog2(DEB_CYC) + 1;

  localparam logic [CW-1:0]     CNT_MAX = CW'(DEB_CYC - 1);
  localparam logic [ADDR_W-1:0] A_MASK  = ADDR_W'(ADDR_MASK);
  localparam logic [ADDR_W-1:0] A_IR    = ADDR_W'(ADDR_IR);
  localparam logic [ADDR_W-1:0] A_SW    = ADDR_W'(ADDR_SW);
  localparam logic [ADDR_W-1:0] A_EVT   = ADDR_W'(ADDR_EVT);

  logic [NCH-1:0] raw;
  logic [NCH-1:0] sync_p0;
  logic [NCH-1:0] sync_p1;
  logic [NCH-1:0] stable;
  logic [NCH-1:0] stable_nxt;
  logic [NCH-1:0] stable_d;
  logic [NCH-1:0] rise;
  logic [NCH-1:0] evt;
  logic [NCH-1:0] evt_nxt;
  logic [NCH-1:0] clr;
  logic [NCH-1:0] mask;
  logic [CW-1:0]  cnt     [NCH];
  logic [CW-1:0]  cnt_nxt [NCH];

  logic wr_evt;
  logic wr_mask;
  logic wdata_unused;

  assign raw          = {sw, IR};
  assign wr_evt       = MemWrite && (dir == A_EVT);
  assign wr_mask      = MemWrite && (dir == A_MASK);
  assign wdata_unused = ^(WriteData >> NCH);

  // Stage p0/p1: two-flop synchroniser; sync_p1 is the clean per-channel sample
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
    end
  end

  // Debounce: any cycle of agreement with the stable value restarts the count
  always_comb begin
    stable_nxt = stable;
    for (int i = 0; i < NCH; i++) begin
      cnt_nxt[i] = '0;
      if (sync_p1[i] != stable[i]) begin
        if (cnt[i] == CNT_MAX) stable_nxt[i] = sync_p1[i];
        else                   cnt_nxt[i]    = cnt[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stable <= '0;
      for (int i = 0; i < NCH; i++) cnt[i] <= '0;
    end else begin
      stable <= stable_nxt;
      for (int i = 0; i < NCH; i++) cnt[i] <= cnt_nxt[i];
    end
  end

  // Stage: edge detect against the previous stable value; falling edges are ignored
  assign rise = stable & ~stable_d;
  assign clr  = wr_evt ? WriteData[NCH-1:0] : '0;

  // A rise arriving in the same cycle as its clear must not be lost
  assign evt_nxt = (evt & ~clr) | rise;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stable_d <= '0;
      evt      <= '0;
      mask     <= '0;
      irq      <= 1'b0;
    end else begin
      stable_d <= stable;
      evt      <= evt_nxt;
      if (wr_mask) mask <= WriteData[NCH-1:0];
      irq      <= |(evt & mask);
    end
  end

  // Read overlay: peripheral registers replace memory data at their addresses
  always_comb begin
    ReadDataOut = ReadData;
    if (dir == A_IR)        ReadDataOut = 32'(stable[0]);
    else if (dir == A_SW)   ReadDataOut = 32'(stable[NCH-1:1]);
    else if (dir == A_EVT)  ReadDataOut = 32'(evt);
    else if (dir == A_MASK) ReadDataOut = 32'(mask);
  end

endmodule

// File: tb/tb_mmio_input_ctrl.sv
// Scoreboard bench for mmio_input_ctrl: stimulus queues expected read/irq values, a negedge
// monitor pops and compares them against the DUT outputs.
module tb_mmio_input_ctrl;

  localparam int SW_W    = 5;
  localparam int DEB_CYC = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic [31:0]     ReadData;
  logic [SW_W-1:0] sw;
  logic            IR;
  logic [4:0]      dir;
  logic            MemWrite;
  logic [31:0]     WriteData;
  logic [31:0]     ReadDataOut;
  logic            irq;

  typedef struct {
    bit          is_irq;
    logic [31:0] exp;
    string       name;
  } sb_t;

  sb_t sb[$];
  int  checks   = 0;
  int  failures = 0;

  mmio_input_ctrl #(.SW_W(SW_W), .DEB_CYC(DEB_CYC)) dut (
    .clk(clk), .reset(reset), .ReadData(ReadData), .sw(sw), .IR(IR), .dir(dir),
    .MemWrite(MemWrite), .WriteData(WriteData), .ReadDataOut(ReadDataOut), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_n(input int n);
    repeat (n) tick();
  endtask

  task automatic exp_rd(input logic [4:0] a, input logic [31:0] v, input string n);
    sb_t e;
    dir      = a;
    e.is_irq = 1'b0;
    e.exp    = v;
    e.name   = n;
    sb.push_back(e);
  endtask

  task automatic exp_irq(input logic v, input string n);
    sb_t e;
    e.is_irq = 1'b1;
    e.exp    = {31'b0, v};
    e.name   = n;
    sb.push_back(e);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    dir       = a;
    WriteData = d;
    MemWrite  = 1'b1;
    tick();
    MemWrite  = 1'b0;
    WriteData = '0;
  endtask

  // Monitor: compares every queued expectation at the falling edge
  initial begin
    forever begin
      @(negedge clk);
      while (sb.size() > 0) begin
        sb_t         e;
        logic [31:0] act;
        e   = sb.pop_front();
        act = e.is_irq ? {31'b0, irq} : ReadDataOut;
        checks++;
        if (act !== e.exp) begin
          failures++;
          $display("FAIL %s: actual=%h required=%h", e.name, act, e.exp);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; dir = 5'd7; ReadData = 32'hDEADBEEF; WriteData = '0;
    MemWrite = 1'b0; sw = '0; IR = 1'b0;
    tick();

    // T1: reset state and pass-through
    exp_rd(5'd7, 32'hDEADBEEF, "t1_pass");
    exp_irq(1'b0, "t1_irq");
    tick(); exp_rd(5'd28, 32'h0, "t1_mask");
    tick(); exp_rd(5'd29, 32'h0, "t1_ir");
    tick(); exp_rd(5'd30, 32'h0, "t1_sw");
    tick(); exp_rd(5'd31, 32'h0, "t1_evt");
    tick();
    reset = 1'b0;
    ReadData = 32'h12345678;
    exp_rd(5'd5, 32'h12345678, "t1_pass2");
    tick();

    // T2: switch debounce latency and event
    sw = 5'b00101;
    for (int j = 1; j <= 18; j++) begin
      tick();
      exp_rd(5'd30, (j >= 18) ? 32'h5 : 32'h0, "t2_sw_latency");
    end
    tick();
    exp_rd(5'd31, 32'hA, "t2_evt");
    exp_irq(1'b0, "t2_irq_masked");
    wr(5'd31, 32'hFFFFFFFF);
    exp_rd(5'd31, 32'h0, "t2_w1c");
    sw = '0;
    wait_n(DEB_CYC + 4);
    exp_rd(5'd30, 32'h0, "t2_sw_fall");
    tick();
    exp_rd(5'd31, 32'h0, "t2_no_fall_evt");
    wr(5'd30, 32'h1F);
    exp_rd(5'd30, 32'h0, "t2_ro_store");
    tick();

    // T3: 15-cycle IR pulses with 1-cycle gaps are rejected
    for (int p = 0; p < 3; p++) begin
      IR = 1'b1;
      repeat (15) begin tick(); exp_rd(5'd29, 32'h0, "t3_ir_glitch"); end
      IR = 1'b0;
      tick(); exp_rd(5'd29, 32'h0, "t3_ir_glitch");
    end
    wait_n(4);
    exp_rd(5'd31, 32'h0, "t3_evt");
    tick();

    // T4: masked interrupt, W1C and irq release
    wr(5'd28, 32'h1);
    exp_rd(5'd28, 32'h1, "t4_mask");
    IR = 1'b1;
    for (int j = 1; j <= 20; j++) begin
      tick();
      if (j == 17) exp_rd(5'd29, 32'h0, "t4_ir_early");
      if (j == 18) exp_rd(5'd29, 32'h1, "t4_ir");
      if (j == 19) exp_rd(5'd31, 32'h1, "t4_evt");
      exp_irq(j >= 20, "t4_irq_timing");
    end
    wr(5'd31, 32'h1);
    exp_rd(5'd31, 32'h0, "t4_w1c");
    exp_irq(1'b1, "t4_irq_hold");
    tick();
    exp_irq(1'b0, "t4_irq_clr");
    sw = 5'b00001;
    for (int j = 1; j <= 21; j++) begin
      tick();
      if (j == 19) exp_rd(5'd31, 32'h2, "t4_sw_evt");
      if (j >= 19) exp_irq(1'b0, "t4_irq_unmasked_bit");
    end

    // T5: set wins over simultaneous W1C
    sw = '0;
    wait_n(DEB_CYC + 4);
    exp_rd(5'd31, 32'h2, "t5_fall_keeps_evt");
    tick();
    exp_rd(5'd30, 32'h0, "t5_sw_low");
    sw = 5'b00001;
    wait_n(18);
    dir = 5'd31; WriteData = 32'h2; MemWrite = 1'b1;
    tick();
    MemWrite = 1'b0; WriteData = '0;
    exp_rd(5'd31, 32'h2, "t5_set_wins");
    wr(5'd31, 32'h2);
    exp_rd(5'd31, 32'h0, "t5_clear");
    tick();

    // T6: reset mid-debounce, inputs held high through reset
    sw = 5'b00011;
    wait_n(DEB_CYC);
    reset = 1'b1;
    exp_rd(5'd28, 32'h0, "t6_rst_mask");
    exp_irq(1'b0, "t6_rst_irq");
    tick(); exp_rd(5'd29, 32'h0, "t6_rst_ir");
    tick(); exp_rd(5'd30, 32'h0, "t6_rst_sw");
    tick(); exp_rd(5'd31, 32'h0, "t6_rst_evt");
    reset = 1'b0;
    for (int j = 1; j <= 20; j++) begin
      tick();
      if (j == 16) exp_rd(5'd29, 32'h0, "t6_ir_early");
      if (j == 17) exp_rd(5'd30, 32'h0, "t6_sw_early");
      if (j == 18) exp_rd(5'd30, 32'h3, "t6_sw");
      if (j == 19) exp_rd(5'd31, 32'h7, "t6_evt");
      if (j == 20) exp_irq(1'b0, "t6_irq_mask_cleared");
    end

    tick();
    tick();
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_drain: actual=%0d required=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
